// File: rtl/uart_transmitter_if.sv
// Parallel-side signals of the UART transmitter, plus the FSM state for
// observation.
//
// Handshake: tx_en is a start request, sampled every clk. It is accepted only
// while busy is low. busy rises on the accepting edge and stays high until the
// stop bit ends. done is a one-clk pulse on that same edge. There is no
// backpressure and no queuing: a request made while busy is high is dropped.
interface uart_transmitter_if #(
  parameter int WIDTH = 8
);
  logic             BCLK;
  logic             tx_en;
  logic [WIDTH-1:0] tx_data;
  logic             tx;
  logic             busy;
  logic             done;
  logic [2:0]       state;

  modport master (
    output BCLK, tx_en, tx_data,
    input  tx, busy, done, state
  );

  modport slave (
    input  BCLK, tx_en, tx_data,
    output tx, busy, done, state
  );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter. It sends a start bit, then WIDTH data bits MSB first, then
// an optional parity bit, then one stop bit. Every bit boundary falls on a BCLK
// tick. tx is driven straight from a flop, so the line never glitches.
module uart_transmitter #(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                clk,
  input  logic                arst,
  uart_transmitter_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               par_q, par_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Next-state and output decode. Outside IDLE, every transition waits for a
  // BCLK tick.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    par_d   = par_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.tx_en) begin
          // Parity is taken from the whole byte here, because shifting
          // destroys the byte as it is sent.
          shift_d = bus.tx_data;
          par_d   = (^bus.tx_data) ^ (PARITY_ODD != 0);
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.BCLK) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bus.BCLK) begin
          tx_d    = shift_q[WIDTH-1];
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.BCLK) begin
          if (cnt_q != '0) begin
            shift_d = shift_q << 1;
            tx_d    = shift_d[WIDTH-1];
            cnt_d   = cnt_q - CNT_W'(1);
          end else if (PARITY_EN != 0) begin
            tx_d    = par_q;
            state_d = PARITY;
          end else begin
            tx_d    = 1'b1;
            state_d = STOP;
          end
        end
      end
      PARITY: begin
        if (bus.BCLK) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (bus.BCLK) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any frame in flight without
  // producing a done pulse.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      par_q   <= 1'b0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      par_q   <= par_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter. One instance has no parity, one has
// even parity and one has odd parity. All three are driven from the same
// stimulus. Expected line bits go into a queue when a byte is requested, and
// are popped on each BCLK tick.
module tb_uart_transmitter;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic         bclk;
  logic         tx_en;
  logic [W-1:0] tx_data;

  uart_transmitter_if #(.WIDTH(W)) if0 ();
  uart_transmitter_if #(.WIDTH(W)) if1 ();
  uart_transmitter_if #(.WIDTH(W)) if2 ();

  assign if0.BCLK = bclk;  assign if0.tx_en = tx_en;  assign if0.tx_data = tx_data;
  assign if1.BCLK = bclk;  assign if1.tx_en = tx_en;  assign if1.tx_data = tx_data;
  assign if2.BCLK = bclk;  assign if2.tx_en = tx_en;  assign if2.tx_data = tx_data;

  uart_transmitter #(.WIDTH(W), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
    .clk(clk), .arst(arst), .bus(if0));
  uart_transmitter #(.WIDTH(W), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .arst(arst), .bus(if1));
  uart_transmitter #(.WIDTH(W), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .arst(arst), .bus(if2));

  // ---------------- scoreboard ----------------
  logic [0:0]   exp_q[$];
  logic [W-1:0] byte_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int done_cnt0   = 0;

  always @(posedge clk) if (if0.done === 1'b1) done_cnt0++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      1:       return if1.tx;
      2:       return if2.tx;
      default: return if0.tx;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      1:       return if1.busy;
      2:       return if2.busy;
      default: return if0.busy;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      1:       return if1.done;
      2:       return if2.done;
      default: return if0.done;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Every driver action happens 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    bclk = 1'b1;
    @(posedge clk);
    #1;
    bclk = 1'b0;
  endtask

  task automatic accept(input logic [W-1:0] d);
    tx_en   = 1'b1;
    tx_data = d;
    @(posedge clk);
    #1;
    tx_en   = 1'b0;
    tx_data = W'($urandom_range(0, 255));
  endtask

  // Expected line: start, data MSB first, optional parity, stop.
  task automatic push_frame(input logic [W-1:0] d, input bit pe, input bit odd);
    exp_q.push_back(1'b0);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back((^d) ^ odd);
    exp_q.push_back(1'b1);
  endtask

  // Runs one frame at one tick per (gap+1) clks, checking every bit and the
  // hold between ticks. Optionally injects a second request after tick inj_at.
  task automatic run_frame(input int sel, input int gap, input int inj_at,
                           input logic [W-1:0] inj_d);
    int n;
    logic [0:0] b;
    n = exp_q.size();
    for (int k = 1; k <= n; k++) begin
      tick();
      b = exp_q.pop_front();
      chk($sformatf("tx_bit%0d", k), 32'(get_tx(sel)), 32'(b));
      chk($sformatf("busy_bit%0d", k), 32'(get_busy(sel)), 32'd1);
      chk($sformatf("done_early%0d", k), 32'(get_done(sel)), 32'd0);
      if (k == inj_at) begin
        tx_en   = 1'b1;
        tx_data = inj_d;
        idle(1);
        tx_en   = 1'b0;
        idle(gap - 1);
      end else begin
        idle(gap);
      end
      chk($sformatf("tx_hold%0d", k), 32'(get_tx(sel)), 32'(b));
    end
    tick();
    chk("done_pulse", 32'(get_done(sel)), 32'd1);
    chk("busy_end", 32'(get_busy(sel)), 32'd0);
    chk("tx_end", 32'(get_tx(sel)), 32'd1);
    idle(1);
    chk("done_one_clk", 32'(get_done(sel)), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int low_cnt;
    logic [W-1:0] rx_byte;
    logic [0:0]   b;

    arst = 1'b1; bclk = 1'b0; tx_en = 1'b0; tx_data = '0;
    idle(2);
    chk("rst_tx", 32'(if0.tx), 32'd1);
    chk("rst_busy", 32'(if0.busy), 32'd0);
    chk("rst_done", 32'(if0.done), 32'd0);
    chk("rst_state", 32'(if0.state), 32'd0);
    arst = 1'b0;
    idle(3);

    // 1: 0xA5 with a tick every 16 clks.
    base = done_cnt0;
    push_frame(8'hA5, 1'b0, 1'b0);
    accept(8'hA5);
    chk("t1_busy_acc", 32'(if0.busy), 32'd1);
    chk("t1_state_load", 32'(if0.state), 32'd1);
    run_frame(0, 15, 0, '0);
    chk("t1_done_count", 32'(done_cnt0 - base), 32'd1);

    // 2: loopback decode of 0x3C. The acceptance edge also carries a tick,
    //    which must not start the frame.
    byte_q.push_back(8'h3C);
    bclk = 1'b1; tx_en = 1'b1; tx_data = 8'h3C;
    idle(1);
    bclk = 1'b0; tx_en = 1'b0;
    chk("t2_acc_tick_ignored", 32'(if0.tx), 32'd1);
    chk("t2_state_load", 32'(if0.state), 32'd1);
    idle(3);
    tick();
    chk("t2_start_bit", 32'(if0.tx), 32'd0);
    rx_byte = '0;
    for (int i = 0; i < W; i++) begin
      idle(3);
      tick();
      rx_byte = {rx_byte[W-2:0], if0.tx};
    end
    idle(3);
    tick();
    chk("t2_stop_bit", 32'(if0.tx), 32'd1);
    idle(3);
    tick();
    chk("t2_rx_done", 32'(if0.done), 32'd1);
    chk("t2_rx_byte", 32'(rx_byte), 32'(byte_q.pop_front()));
    idle(2);

    // 3: a request for 0xFF arrives in the middle of a 0x00 frame and is dropped.
    base = done_cnt0;
    push_frame(8'h00, 1'b0, 1'b0);
    accept(8'h00);
    run_frame(0, 15, 3, 8'hFF);
    idle(20);
    chk("t3_no_queue_busy", 32'(if0.busy), 32'd0);
    chk("t3_done_count", 32'(done_cnt0 - base), 32'd1);

    // 4: async reset in the DATA state of 0x81, then a clean resend.
    base = done_cnt0;
    accept(8'h81);
    tick(); tick(); tick();
    chk("t4_in_data", 32'(if0.state), 32'd3);
    chk("t4_tx_d6", 32'(if0.tx), 32'd0);
    #2 arst = 1'b1;
    #1;
    chk("t4_async_tx", 32'(if0.tx), 32'd1);
    chk("t4_async_busy", 32'(if0.busy), 32'd0);
    chk("t4_async_state", 32'(if0.state), 32'd0);
    idle(2);
    arst = 1'b0;
    tick(); idle(2); tick(); idle(2); tick(); idle(2);
    chk("t4_no_done", 32'(done_cnt0 - base), 32'd0);
    chk("t4_idle_after", 32'(if0.busy), 32'd0);
    push_frame(8'h81, 1'b0, 1'b0);
    accept(8'h81);
    run_frame(0, 3, 0, '0);
    chk("t4_resend_done", 32'(done_cnt0 - base), 32'd1);

    // 5: BCLK tied high. The second request is made in the done cycle.
    arst = 1'b1; idle(1); arst = 1'b0; idle(1);
    bclk = 1'b1; tx_en = 1'b1; tx_data = 8'hAA;
    push_frame(8'hAA, 1'b0, 1'b0);
    idle(1);
    tx_en = 1'b0;
    chk("t5_first_load", 32'(if0.state), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      b = exp_q.pop_front();
      chk($sformatf("t5a_bit%0d", k), 32'(if0.tx), 32'(b));
    end
    idle(1);
    chk("t5_done1", 32'(if0.done), 32'd1);
    tx_en = 1'b1; tx_data = 8'h55;
    push_frame(8'h55, 1'b0, 1'b0);
    idle(1);
    tx_en = 1'b0;
    low_cnt = 0;
    if (if0.done === 1'b0) low_cnt++;
    chk("t5_second_load", 32'(if0.state), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      if (if0.done === 1'b0) low_cnt++;
      b = exp_q.pop_front();
      chk($sformatf("t5b_bit%0d", k), 32'(if0.tx), 32'(b));
    end
    idle(1);
    chk("t5_done2", 32'(if0.done), 32'd1);
    chk("t5_done_spacing", 32'(low_cnt), 32'd11);
    bclk = 1'b0;
    idle(2);

    // 6: parity on 0x07, first even (bit 1) and then odd (bit 0).
    arst = 1'b1; idle(1); arst = 1'b0; idle(1);
    push_frame(8'h07, 1'b1, 1'b0);
    chk("t6_even_par_bit", 32'(exp_q[9]), 32'd1);
    accept(8'h07);
    run_frame(1, 2, 0, '0);
    idle(2);
    push_frame(8'h07, 1'b1, 1'b1);
    chk("t6_odd_par_bit", 32'(exp_q[9]), 32'd0);
    accept(8'h07);
    run_frame(2, 2, 0, '0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
